// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vending controller slice.
package vend_pkg;

   localparam int NUM_ITEMS_DEF          = 4;
   localparam int CURRENCY_WIDTH_DEF     = 8;
   localparam int TOTAL_AMOUNT_WIDTH_DEF = 15;
   localparam int TIMEOUT_CYCLES_DEF     = 1000;
   localparam int STOCK_WIDTH            = 8;

   // Controller states; exported unchanged on the state_dbg port.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_COLLECT  = 3'd1,
      S_CHECK    = 3'd2,
      S_DISPENSE = 3'd3,
      S_REFUND   = 3'd4
   } vend_state_t;

   // Index width for a table of n slots; a single slot still gets one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vend_item_table.sv
// Price and stock storage: one write port, one decrement port, one
// asynchronous read port.
module vend_item_table
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS      = NUM_ITEMS_DEF,
   parameter int CURRENCY_WIDTH = CURRENCY_WIDTH_DEF,
   localparam int IDX_W         = idx_width(NUM_ITEMS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_wr_en,
   input  logic [IDX_W-1:0]          cfg_idx,
   input  logic [CURRENCY_WIDTH-1:0] cfg_price,
   input  logic [STOCK_WIDTH-1:0]    cfg_stock,
   input  logic                      dec_en,
   input  logic [IDX_W-1:0]          dec_idx,
   input  logic [IDX_W-1:0]          rd_idx,
   output logic [CURRENCY_WIDTH-1:0] rd_price,
   output logic [STOCK_WIDTH-1:0]    rd_stock
);

   logic [CURRENCY_WIDTH-1:0] price_q [NUM_ITEMS];
   logic [STOCK_WIDTH-1:0]    stock_q [NUM_ITEMS];

   // Table update: a decrement never wraps below zero; a config write
   // replaces both fields of its slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            price_q[i] <= '0;
            stock_q[i] <= '0;
         end
      end else begin
         if (dec_en && (int'(dec_idx) < NUM_ITEMS) && (stock_q[dec_idx] != '0)) begin
            stock_q[dec_idx] <= stock_q[dec_idx] - STOCK_WIDTH'(1);
         end
         if (cfg_wr_en && (int'(cfg_idx) < NUM_ITEMS)) begin
            price_q[cfg_idx] <= cfg_price;
            stock_q[cfg_idx] <= cfg_stock;
         end
      end
   end

   // Combinational read; an out-of-range index reads as an empty, free slot.
   always_comb begin
      rd_price = '0;
      rd_stock = '0;
      if (int'(rd_idx) < NUM_ITEMS) begin
         rd_price = price_q[rd_idx];
         rd_stock = stock_q[rd_idx];
      end
   end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: collects credit from the coin accumulator, checks a
// selection against the item table, dispenses with change or refunds.
// Every output pulse (item_valid, change_valid, clear_acc, sold_out,
// insufficient) is a single-cycle strobe with no back-pressure: the consumer
// must take it in the cycle it is high. All outputs are registered, so the
// pulses belonging to DISPENSE/REFUND appear in the cycle after that state.
module vend_controller
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS          = NUM_ITEMS_DEF,
   parameter int CURRENCY_WIDTH     = CURRENCY_WIDTH_DEF,
   parameter int TOTAL_AMOUNT_WIDTH = TOTAL_AMOUNT_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF,
   localparam int IDX_W             = idx_width(NUM_ITEMS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [TOTAL_AMOUNT_WIDTH-1:0] total_amount,
   input  logic                          currency_done,
   input  logic                          item_sel_valid,
   input  logic [IDX_W-1:0]              item_sel_idx,
   input  logic                          cancel,
   input  logic                          cfg_wr_en,
   input  logic [IDX_W-1:0]              cfg_idx,
   input  logic [CURRENCY_WIDTH-1:0]     cfg_price,
   input  logic [STOCK_WIDTH-1:0]        cfg_stock,
   output logic                          clear_acc,
   output logic                          item_valid,
   output logic [IDX_W-1:0]              item_out,
   output logic                          change_valid,
   output logic [TOTAL_AMOUNT_WIDTH-1:0] change_out,
   output logic                          sold_out,
   output logic                          insufficient,
   output logic                          busy,
   output vend_state_t                   state_dbg
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   vend_state_t               state;
   logic [TIMER_W-1:0]        timer;
   logic [IDX_W-1:0]          sel_idx;
   logic [CURRENCY_WIDTH-1:0] rd_price;
   logic [STOCK_WIDTH-1:0]    rd_stock;
   logic                      tbl_wr_en;
   logic                      dec_en;
   logic [TOTAL_AMOUNT_WIDTH-1:0] price_ext;

   // Configuration is only accepted while no transaction is in flight.
   assign tbl_wr_en = cfg_wr_en && (state == S_IDLE);
   // The decrement lands on the edge that leaves DISPENSE; rst wins inside the table.
   assign dec_en    = (state == S_DISPENSE);
   assign price_ext = TOTAL_AMOUNT_WIDTH'(rd_price);
   assign state_dbg = state;

   vend_item_table #(
      .NUM_ITEMS      (NUM_ITEMS),
      .CURRENCY_WIDTH (CURRENCY_WIDTH)
   ) u_item_table (
      .clk       (clk),
      .rst       (rst),
      .cfg_wr_en (tbl_wr_en),
      .cfg_idx   (cfg_idx),
      .cfg_price (cfg_price),
      .cfg_stock (cfg_stock),
      .dec_en    (dec_en),
      .dec_idx   (sel_idx),
      .rd_idx    (sel_idx),
      .rd_price  (rd_price),
      .rd_stock  (rd_stock)
   );

   // Transaction FSM with registered pulse outputs and the idle timeout timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         timer        <= '0;
         sel_idx      <= '0;
         busy         <= 1'b0;
         clear_acc    <= 1'b0;
         item_valid   <= 1'b0;
         item_out     <= '0;
         change_valid <= 1'b0;
         change_out   <= '0;
         sold_out     <= 1'b0;
         insufficient <= 1'b0;
      end else begin
         clear_acc    <= 1'b0;
         item_valid   <= 1'b0;
         item_out     <= '0;
         change_valid <= 1'b0;
         change_out   <= '0;
         sold_out     <= 1'b0;
         insufficient <= 1'b0;
         case (state)
            S_IDLE: begin
               if (currency_done) begin
                  state <= S_COLLECT;
                  busy  <= 1'b1;
                  timer <= '0;
               end
            end
            S_COLLECT: begin
               // cancel beats a same-cycle selection; a coin restarts the window.
               if (cancel) begin
                  state <= S_REFUND;
               end else if (item_sel_valid) begin
                  state   <= S_CHECK;
                  sel_idx <= item_sel_idx;
               end else if (currency_done) begin
                  timer <= '0;
               end else if (timer == TIMER_LAST) begin
                  state <= S_REFUND;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            S_CHECK: begin
               if (rd_stock == '0) begin
                  sold_out <= 1'b1;
                  state    <= S_COLLECT;
                  timer    <= '0;
               end else if (total_amount < price_ext) begin
                  insufficient <= 1'b1;
                  state        <= S_COLLECT;
                  timer        <= '0;
               end else begin
                  state <= S_DISPENSE;
               end
            end
            S_DISPENSE: begin
               item_valid   <= 1'b1;
               item_out     <= sel_idx;
               clear_acc    <= 1'b1;
               change_valid <= 1'b1;
               change_out   <= total_amount - price_ext;
               state        <= S_IDLE;
               busy         <= 1'b0;
            end
            S_REFUND: begin
               clear_acc    <= 1'b1;
               change_valid <= 1'b1;
               change_out   <= total_amount;
               state        <= S_IDLE;
               busy         <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: a coin accumulator stands in for currency_input,
// a purchase-level model predicts every output pulse, and a monitor compares
// each pulse the DUT presents against the head of the expected queue.
module tb_vend_controller;
   import vend_pkg::*;

   localparam int NI   = 4;
   localparam int CW   = 8;
   localparam int TW   = 15;
   localparam int TO   = 24;
   localparam int EV_W = 1 + 2 + 1 + TW + 1 + 1 + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [TW-1:0] total_amount;
   logic          currency_done = 1'b0;
   logic [CW-1:0] coin_val = '0;
   logic          item_sel_valid = 1'b0;
   logic [1:0]    item_sel_idx = '0;
   logic          cancel = 1'b0;
   logic          cfg_wr_en = 1'b0;
   logic [1:0]    cfg_idx = '0;
   logic [CW-1:0] cfg_price = '0;
   logic [7:0]    cfg_stock = '0;
   logic          clear_acc, item_valid, change_valid, sold_out, insufficient, busy;
   logic [1:0]    item_out;
   logic [TW-1:0] change_out;
   vend_state_t   state_dbg;

   vend_controller #(
      .NUM_ITEMS          (NI),
      .CURRENCY_WIDTH     (CW),
      .TOTAL_AMOUNT_WIDTH (TW),
      .TIMEOUT_CYCLES     (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .total_amount   (total_amount),
      .currency_done  (currency_done),
      .item_sel_valid (item_sel_valid),
      .item_sel_idx   (item_sel_idx),
      .cancel         (cancel),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_idx        (cfg_idx),
      .cfg_price      (cfg_price),
      .cfg_stock      (cfg_stock),
      .clear_acc      (clear_acc),
      .item_valid     (item_valid),
      .item_out       (item_out),
      .change_valid   (change_valid),
      .change_out     (change_out),
      .sold_out       (sold_out),
      .insufficient   (insufficient),
      .busy           (busy),
      .state_dbg      (state_dbg)
   );

   // Coin accumulator: a coin lands on the edge of its currency_done pulse.
   always @(posedge clk) begin
      if (rst)                total_amount <= '0;
      else if (clear_acc)     total_amount <= '0;
      else if (currency_done) total_amount <= total_amount + TW'(coin_val);
   end

   // ---------------- reference model ----------------
   int price_m [NI];
   int stock_m [NI];
   int credit = 0;
   bit in_session = 0;

   logic [EV_W-1:0] exp_q [$];
   int compared = 0;
   int mismatched = 0;

   logic [EV_W-1:0] out_vec;
   assign out_vec = {item_valid, item_out, change_valid, change_out, sold_out, insufficient, clear_acc};

   function automatic logic [EV_W-1:0] ev(input logic iv, input int item, input logic cv,
                                          input int chg, input logic so, input logic ins,
                                          input logic ca);
      return {iv, 2'(item), cv, TW'(chg), so, ins, ca};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         price_m[i] = 0;
         stock_m[i] = 0;
      end
      credit = 0;
      in_session = 0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [EV_W-1:0] e;
      if (!rst && (item_valid || change_valid || sold_out || insufficient)) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_pulse: got iv=%0d item=%0d cv=%0d chg=%0d so=%0d ins=%0d ca=%0d, required no pulse",
                     item_valid, item_out, change_valid, change_out, sold_out, insufficient, clear_acc);
         end else begin
            e = exp_q.pop_front();
            if (out_vec !== e) begin
               mismatched++;
               $display("FAIL pulse: got iv=%0d item=%0d cv=%0d chg=%0d so=%0d ins=%0d ca=%0d, required iv=%0d item=%0d cv=%0d chg=%0d so=%0d ins=%0d ca=%0d",
                        item_valid, item_out, change_valid, change_out, sold_out, insufficient, clear_acc,
                        e[EV_W-1], e[EV_W-2 -: 2], e[EV_W-4], e[EV_W-5 -: TW], e[2], e[1], e[0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic cfg_write(input int idx, input int p, input int s);
      cfg_idx   = 2'(idx);
      cfg_price = CW'(p);
      cfg_stock = 8'(s);
      cfg_wr_en = 1'b1;
      tick();
      cfg_wr_en = 1'b0;
      if (!in_session) begin
         price_m[idx] = p;
         stock_m[idx] = s;
      end
   endtask

   task automatic coin(input int v);
      coin_val      = CW'(v);
      currency_done = 1'b1;
      tick();
      currency_done = 1'b0;
      credit += v;
      in_session = 1;
   endtask

   // Selection, optionally with a coin in the same cycle (coin_v >= 0).
   task automatic do_select(input int idx, input int coin_v);
      bit was = in_session;
      item_sel_idx   = 2'(idx);
      item_sel_valid = 1'b1;
      if (coin_v >= 0) begin
         coin_val      = CW'(coin_v);
         currency_done = 1'b1;
         credit += coin_v;
         in_session = 1;
      end
      tick();
      item_sel_valid = 1'b0;
      currency_done  = 1'b0;
      if (was) begin
         if (stock_m[idx] == 0) begin
            exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 0));
         end else if (credit < price_m[idx]) begin
            exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 0));
         end else begin
            exp_q.push_back(ev(1, idx, 1, credit - price_m[idx], 0, 0, 1));
            stock_m[idx] -= 1;
            credit = 0;
            in_session = 0;
         end
      end
      tick(3);
   endtask

   // Cancel, optionally with a same-cycle selection that must be discarded.
   task automatic do_cancel(input bit with_sel, input int idx);
      cancel         = 1'b1;
      item_sel_valid = with_sel;
      item_sel_idx   = 2'(idx);
      tick();
      cancel         = 1'b0;
      item_sel_valid = 1'b0;
      if (in_session) begin
         exp_q.push_back(ev(0, 0, 1, credit, 0, 0, 1));
         credit = 0;
         in_session = 0;
      end
      tick(2);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      model_reset();
      tick(3);
      chk("reset_outputs", int'(out_vec), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_state", int'(state_dbg), int'(S_IDLE));
      rst = 1'b0;
      tick();

      // Nominal purchase, then a config write while busy must be ignored.
      cfg_write(1, 25, 2);
      coin(20);
      chk("busy_in_collect", int'(busy), 1);
      coin(10);
      do_select(1, -1);
      chk("idle_after_dispense", int'(state_dbg), int'(S_IDLE));
      chk("busy_after_dispense", int'(busy), 0);
      coin(30);
      cfg_write(1, 200, 0);
      do_select(1, -1);
      coin(30);
      do_select(1, -1);
      do_cancel(0, 0);

      // Sold out keeps collecting; cancel refunds the full credit.
      cfg_write(2, 10, 0);
      coin(50);
      do_select(2, -1);
      chk("collect_after_sold_out", int'(state_dbg), int'(S_COLLECT));
      do_cancel(0, 0);

      // Insufficient credit, then the idle timeout refunds it.
      cfg_write(0, 100, 5);
      coin(50);
      do_select(0, -1);
      exp_q.push_back(ev(0, 0, 1, credit, 0, 0, 1));
      credit = 0;
      in_session = 0;
      n = 0;
      while (!change_valid && n < TO + 20) begin
         tick();
         n++;
      end
      chk("timeout_latency", n, TO - 1);
      tick();

      // Selection and cancel in IDLE are ignored.
      do_select(0, -1);
      do_cancel(1, 0);

      // Cancel beats a same-cycle selection; free item.
      cfg_write(0, 0, 5);
      coin(7);
      do_cancel(1, 0);

      // Coin and selection in the same cycle pay exactly.
      cfg_write(0, 10, 5);
      coin(0);
      do_select(0, 10);

      // Reset during DISPENSE suppresses every pulse and clears the table.
      cfg_write(3, 5, 3);
      coin(10);
      item_sel_idx   = 2'd3;
      item_sel_valid = 1'b1;
      tick();
      item_sel_valid = 1'b0;
      tick();
      chk("in_dispense", int'(state_dbg), int'(S_DISPENSE));
      rst = 1'b1;
      tick();
      chk("reset_in_dispense_outputs", int'(out_vec), 0);
      chk("reset_in_dispense_busy", int'(busy), 0);
      rst = 1'b0;
      model_reset();
      tick(2);
      chk("no_late_pulse", int'(out_vec), 0);
      coin(10);
      do_select(3, -1);
      do_cancel(0, 0);

      // Randomised sessions against the purchase model.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 0)
            cfg_write($urandom_range(0, NI - 1), $urandom_range(0, 120), $urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 0) do_select($urandom_range(0, NI - 1), -1);
            else do_cancel(1, $urandom_range(0, NI - 1));
         end
         repeat ($urandom_range(1, 3)) coin($urandom_range(0, 60));
         for (int a = 0; a < 3 && in_session; a++) begin
            case ($urandom_range(0, 5))
               0:       do_cancel($urandom_range(0, 1), $urandom_range(0, NI - 1));
               1:       do_select($urandom_range(0, NI - 1), $urandom_range(1, 30));
               default: do_select($urandom_range(0, NI - 1), -1);
            endcase
            if (in_session && $urandom_range(0, 1) == 1) coin($urandom_range(0, 60));
         end
         if (in_session) do_cancel(0, 0);
      end

      tick(5);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #2000000;
      mismatched++;
      $display("FAIL watchdog: got no completion, required completion before time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
